// File: rtl/ctrl_sequencer.sv
// Four-step control sequencer for a small register-file processor: fetches an
// instruction in T0 and decodes (step, IR, iRun, iGnz) into datapath strobes.
module ctrl_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  localparam int RSEL_W = $clog2(NREG),
  localparam int IR_W   = 3 + 2 * RSEL_W
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iRun,
  input  logic [IR_W-1:0]   iDin,
  input  logic              iGnz,
  output logic              oIr_en,
  output logic              oDin_en,
  output logic              oAin,
  output logic              oGin,
  output logic              oGout,
  output logic              oAddr_en,
  output logic              oDout_en,
  output logic              oW,
  output logic              oRout_en,
  output logic [1:0]        oAluOp,
  output logic [RSEL_W-1:0] oRout,
  output logic [NREG-1:0]   oRin,
  output logic              oDone,
  output logic [1:0]        oState,
  output logic [IR_W-1:0]   oIr
);

  // DATA_W is carried for datapath pairing only; reject unusable parameter sets early.
  if (!(NREG == 2 || NREG == 4 || NREG == 8 || NREG == 16) || DATA_W < 1) begin : gBadParam
    $error("ctrl_sequencer: NREG must be 2, 4, 8 or 16 and DATA_W positive");
  end

  typedef enum logic [1:0] {T0 = 2'b00, T1 = 2'b01, T2 = 2'b10, T3 = 2'b11} state_t;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_LD   = 3'b100,
    OP_ST   = 3'b101,
    OP_MVNZ = 3'b110,
    OP_AND  = 3'b111
  } opcode_t;

  state_t            state, stateNext;
  logic [IR_W-1:0]   ir;
  opcode_t           op;
  logic [RSEL_W-1:0] rx, ry;

  logic              irEn, dinEn, ain, gin, gout, addrEn, doutEn, wr, routEn, rinEn, done;
  logic [1:0]        aluOp;
  logic [RSEL_W-1:0] routSel;

  assign op = opcode_t'(ir[IR_W-1 -: 3]);
  assign rx = ir[2*RSEL_W-1 -: RSEL_W];
  assign ry = ir[RSEL_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; IR is cleared on reset because it is visible on oIr.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= stateNext;
      if (irEn) ir <= iDin;
    end
  end

  // NOTE: every combinational output is defaulted first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    stateNext = state;
    irEn      = 1'b0;
    dinEn     = 1'b0;
    ain       = 1'b0;
    gin       = 1'b0;
    gout      = 1'b0;
    addrEn    = 1'b0;
    doutEn    = 1'b0;
    wr        = 1'b0;
    routEn    = 1'b0;
    routSel   = '0;
    rinEn     = 1'b0;
    done      = 1'b0;
    aluOp     = 2'b00;
    case (state)
      T0: begin
        irEn = iRun;
        if (iRun) stateNext = T1;
      end
      T1: begin
        stateNext = T0;
        case (op)
          OP_MV:   begin routEn = 1'b1; routSel = ry; rinEn = 1'b1; done = 1'b1; end
          OP_MVI:  begin dinEn = 1'b1; rinEn = 1'b1; done = 1'b1; end
          OP_ADD, OP_SUB, OP_AND: begin
            routEn = 1'b1; routSel = rx; ain = 1'b1; stateNext = T2;
          end
          OP_LD, OP_ST: begin
            routEn = 1'b1; routSel = ry; addrEn = 1'b1; stateNext = T2;
          end
          OP_MVNZ: begin
            routEn  = iGnz;
            routSel = iGnz ? ry : '0;
            rinEn   = iGnz;
            done    = 1'b1;
          end
          default: ;
        endcase
      end
      T2: begin
        stateNext = T0;
        case (op)
          OP_ADD, OP_SUB, OP_AND: begin
            routEn = 1'b1; routSel = ry; gin = 1'b1; stateNext = T3;
            aluOp  = (op == OP_SUB) ? 2'b01 : (op == OP_AND) ? 2'b10 : 2'b00;
          end
          // Memory read latency cycle: nothing driven.
          OP_LD:   stateNext = T3;
          OP_ST:   begin
            routEn = 1'b1; routSel = rx; doutEn = 1'b1; wr = 1'b1; done = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        stateNext = T0;
        case (op)
          OP_ADD, OP_SUB, OP_AND: begin gout = 1'b1; rinEn = 1'b1; done = 1'b1; end
          OP_LD:   begin dinEn = 1'b1; rinEn = 1'b1; done = 1'b1; end
          default: ;
        endcase
      end
      default: stateNext = T0;
    endcase
  end

  // Outputs are held quiet combinationally for as long as reset is asserted.
  assign oIr_en   = iRst_n & irEn;
  assign oDin_en  = iRst_n & dinEn;
  assign oAin     = iRst_n & ain;
  assign oGin     = iRst_n & gin;
  assign oGout    = iRst_n & gout;
  assign oAddr_en = iRst_n & addrEn;
  assign oDout_en = iRst_n & doutEn;
  assign oW       = iRst_n & wr;
  assign oRout_en = iRst_n & routEn;
  assign oDone    = iRst_n & done;
  assign oAluOp   = iRst_n ? aluOp : 2'b00;
  assign oRout    = (iRst_n && routEn) ? routSel : '0;
  assign oRin     = (iRst_n && rinEn) ? ({{(NREG-1){1'b0}}, 1'b1} << rx) : '0;
  assign oState   = iRst_n ? state : T0;
  assign oIr      = ir;

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, datapath width; the block only passes it through and it does not alter control timing.
REQ-002 Parameter NREG, default 8, register count; legal values 2, 4, 8, 16.
REQ-003 Derived parameter RSEL_W = log2(NREG); IR_W = 3 + 2*RSEL_W, with opcode[IR_W-1:IR_W-3], rx next RSEL_W bits, ry lowest RSEL_W bits.
REQ-004 One clock, iClk; reset is synchronous and active-low, iRst_n.
REQ-005 iClk  in  1  clock, all state changes on rising edge.
REQ-006 iRst_n  in  1  synchronous active-low reset.
REQ-007 iRun  in  1  start request, sampled only in T0.
REQ-008 iDin  in  IR_W  instruction bits from data bus.
REQ-009 iGnz  in  1  datapath flag, G register non-zero.
REQ-010 oIr_en, oDin_en, oAin, oGin, oGout, oAddr_en, oDout_en, oW, oRout_en  out  1 each  datapath strobes.
REQ-011 oAluOp  out  2  ALU operation: 00 add, 01 sub, 10 and.
REQ-012 oRout  out  RSEL_W  register read select, valid when oRout_en=1, else 0.
REQ-013 oRin  out  NREG  one-hot register write enables.
REQ-014 oDone  out  1  one-cycle instruction-complete pulse.
REQ-015 oState  out  2  current step T0..T3 (00..11); oIr  out  IR_W  latched instruction.

Function
REQ-016 Internal step FSM T0->T1->T2->T3; each step SHALL last exactly one cycle.
REQ-017 All strobe outputs SHALL be combinational decode of (state, IR, iRun, iGnz); every strobe not listed for a step SHALL be 0.
REQ-018 T0: oIr_en=iRun; if iRun=1, IR<=iDin and next=T1; else stay T0 and hold IR.
REQ-019 Opcode 000 mv, T1: oRout_en, oRout=ry, oRin[rx]=1, oDone=1, next T0.
REQ-020 Opcode 001 mvi, T1: oDin_en, oRin[rx]=1, oDone=1, next T0.
REQ-021 Opcodes 010 add, 011 sub, 111 and: T1 oRout=rx, oAin; T2 oRout=ry, oGin, oAluOp 00/01/10; T3 oGout, oRin[rx], oDone; next T0.
REQ-022 Opcode 100 ld: T1 oRout=ry, oAddr_en; T2 no strobes (memory latency); T3 oDin_en, oRin[rx], oDone; next T0.
REQ-023 Opcode 101 st: T1 oRout=ry, oAddr_en; T2 oRout=rx, oDout_en, oW, oDone; next T0.
REQ-024 Opcode 110 mvnz, T1: if iGnz=1, oRout=ry and oRin[rx]=1; oDone=1 regardless; next T0.
REQ-025 oAluOp SHALL be 00 in every step other than the ALU-op T2.
REQ-026 rx=ry SHALL need no special handling; the decode is identical.
REQ-027 iRun deasserted mid-instruction SHALL NOT abort the instruction; it completes and the FSM returns to T0.
REQ-028 Back-to-back: with iRun held at 1, a new IR fetch SHALL occur in the T0 cycle immediately after oDone.
REQ-029 oRin SHALL always be zero or one-hot.
REQ-030 oDone SHALL never be high for two consecutive cycles.

Reset
REQ-031 iRst_n=0 at a rising edge SHALL force state=T0 and IR=0, overriding any in-progress instruction.
REQ-032 While iRst_n=0, all strobes, oRin, oRout, oAluOp and oDone SHALL be 0, and oState=00.
REQ-033 After reset release, the first fetch SHALL occur at the first T0 edge with iRun=1.

Verification
REQ-034 Reset asserted in T2 of add -> next cycle oState=00, oIr=0, oRin=0, oDone=0.
REQ-035 NREG=8, iRun=1, iDin=010_011_101 (add r3,r5) -> T1 oRout=3,oAin; T2 oRout=5,oGin,oAluOp=00; T3 oGout, oRin=8'h08, oDone; T0 on the fourth cycle after fetch.
REQ-036 mvi r2 (001_010_000) then mv r0,r2 with iRun held high -> oRin=8'h04 with oDin_en, then next T1 oRout=2, oRin=8'h01; oDone pulses in two cycles separated by one T0.
REQ-037 mvnz r1,r4 with iGnz=0 -> oRin=0, oDone=1; repeat with iGnz=1 -> oRout=4, oRin=8'h02.
REQ-038 st r6,r7 -> T1 oRout=7, oAddr_en; T2 oRout=6, oDout_en, oW, oDone; ld r6,r7 -> T2 all strobes 0, T3 oDin_en, oRin=8'h40.
REQ-039 NREG=4 (IR_W=7), iDin=0111110 (sub r3,r2), iRun dropped in T1 -> full sub sequence completes, oRin=4'h8 in T3, then FSM idles in T0 with oIr_en=0.
